char_cell_arbiter: RTL and testbench
====================================

// Module: char_cell_arbiter
// PURPOSE
// Shares one single-port character-cell RAM between the VGA scan-out path and host writes.
// - Grid: 40x30 cells of 8x8 logical pixels. Logical pixel x = hcount[10:2], y = vcount[9:1].
// - Cell word: {color_number[3:0], character_number[5:0]}.
// - Scan reads get strict priority. Host writes are buffered in a small FIFO and drain into idle RAM cycles.
// PARAMETERS
// CELLS       1200  number of valid cell addresses (0..CELLS-1)
// AW          11    cell address width
// DW          10    cell word width
// FIFO_DEPTH  4     host write FIFO depth; must be a power of 2
// PORTS
// clk50        in   1        system clock, 50 MHz
// reset        in   1        synchronous, active-high reset
// host_valid   in   1        host write request
// host_ready   out  1        FIFO can accept; a transfer occurs when host_valid & host_ready
// host_addr    in   AW       cell address to write
// host_data    in   DW       cell word to write
// scan_req     in   1        scan-out read request, one cycle per request
// scan_addr    in   AW       cell address to read
// scan_rvalid  out  1        scan_rdata is valid this cycle
// scan_rdata   out  DW       read data (equals ram_rdata)
// ram_addr     out  AW       RAM address
// ram_we       out  1        RAM write enable
// ram_wdata    out  DW       RAM write data
// ram_rdata    in   DW       RAM read data, 1-cycle latency
// clear_start  in   1        start a screen fill (CLEAR_EN only)
// clear_data   in   DW       fill word, sampled on clear_start
// clear_busy   out  1        fill in progress
// fifo_level   out  $clog2(FIFO_DEPTH)+1   FIFO occupancy
// err_cnt      out  8        dropped out-of-range writes; saturates at 255
// BEHAVIOUR
// - One RAM access per clk50 cycle. Priority: scan_req > CLEAR > FIFO-head write.
// - ram_addr, ram_we and ram_wdata are combinational from the arbitration decision.
// - Scan read:
//   - scan_req=1 drives ram_addr=scan_addr with ram_we=0.
//   - scan_rvalid is registered and asserts on the next cycle; scan_rdata = ram_rdata.
// - FIFO:
//   - host_ready = !full; there is no bypass when full.
//   - Push and pop in the same cycle are allowed when not full.
//   - Entries write to RAM in order. Earliest RAM write is the cycle after acceptance.
// - Out-of-range write (host_addr >= CELLS):
//   - Still accepted (handshake completes) but not enqueued.
//   - err_cnt increments, saturating at 255.
// - Ordering: a scan read of an address with a pending write returns the old data.
// - FSM states:
//   - IDLE: FIFO empty. Goes to DRAIN when the FIFO becomes non-empty; goes to CLEAR on clear_start.
//   - DRAIN: pops the head on every cycle with no scan_req. Returns to IDLE when the FIFO empties.
//   - CLEAR: goes to DRAIN or IDLE after the last fill write.
// - Idle cycles: when no write is granted, ram_addr holds its last value and ram_we=0.
// - Reset values: host_ready=0 during the reset cycle and 1 after it; every other output = 0.
//   The FIFO is emptied and the FSM goes to IDLE.
// - Reset mid-drain or mid-clear: pending writes are discarded and no ram_we follows.
//   RAM contents are left as they are.
// CONFIGURATION
// CHAR_CLEAR_EN defined:
// - A clear_start pulse in IDLE or DRAIN latches clear_data, enters CLEAR and sets clear_busy=1.
// - A fill counter runs 0..CELLS-1, writing clear_data on every cycle with no scan_req.
// - FIFO writes stall during CLEAR; the host may keep enqueuing until the FIFO is full.
// - clear_busy falls on the cycle after the write to address CELLS-1.
// - clear_start while clear_busy=1 is ignored.
// CHAR_CLEAR_EN undefined:
// - clear_start and clear_data are ignored; clear_busy is tied to 0; no CLEAR state exists.
// TESTING
// 1. Reset, then accept addr 5, data 10'h3A5 with scan_req=0
//    -> the next cycle has ram_we=1, ram_addr=5, ram_wdata=10'h3A5 for exactly 1 cycle.
// 2. Hold scan_req=1 for 10 cycles and offer 5 writes
//    -> 4 accepted, then host_ready=0 and fifo_level=4, with no ram_we while scan_req=1.
//    -> The 4 writes issue in order on the 4 cycles after scan_req drops.
// 3. scan_req with addr 41
//    -> ram_addr=41 and ram_we=0 the same cycle; scan_rvalid=1 next cycle with scan_rdata = RAM[41].
// 4. host_addr=1200 -> accepted, no ram_we, err_cnt=1.
//    Then 300 bad writes -> err_cnt=255.
// 5. CHAR_CLEAR_EN: clear_start with clear_data=0 and scan_req every 32nd cycle
//    -> exactly 1200 fill writes; clear_busy falls after 1238 cycles.
//    -> A write to addr 0 queued during the fill lands after the fill.
// 6. Enqueue 3 writes under continuous scan_req, then assert reset for 1 cycle
//    -> fifo_level=0, no ram_we afterwards, host_ready=1 the following cycle.

Source files
------------

// File: rtl/char_cell_arbiter.sv
// char_cell_arbiter: shares one character-cell RAM between scan-out reads and FIFO-buffered host writes; define CHAR_CLEAR_EN to add the screen fill
module char_cell_arbiter #(
  parameter int CELLS      = 1200,
  parameter int AW         = 11,
  parameter int DW         = 10,
  parameter int FIFO_DEPTH = 4,
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int LW = PW + 1
) (
  input  logic          clk50,
  input  logic          reset,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_data,
  input  logic          scan_req,
  input  logic [AW-1:0] scan_addr,
  output logic          scan_rvalid,
  output logic [DW-1:0] scan_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  input  logic          clear_start,
  input  logic [DW-1:0] clear_data,
  output logic          clear_busy,
  output logic [LW-1:0] fifo_level,
  output logic [7:0]    err_cnt
);
`ifdef CHAR_CLEAR_EN
  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, DRAIN} state_t;
`endif
  state_t state_q, state_d;
  logic [AW-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DW-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          rdy_q, rdy_d, rvalid_q, rvalid_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    err_q, err_d;
  logic          accept, push, pop, fill_we;
  logic [AW-1:0] fill_addr;
  logic [DW-1:0] fill_data;
`ifdef CHAR_CLEAR_EN
  logic [AW-1:0] fill_q, fill_d;
  logic [DW-1:0] clr_q, clr_d;
  logic          clr_go;
`else
  logic          unused_clear;
  assign unused_clear = ^{clear_start, clear_data};
`endif
  assign host_ready  = rdy_q;
  assign scan_rvalid = rvalid_q;
  assign scan_rdata  = ram_rdata;
  assign fifo_level  = cnt_q;
  assign err_cnt     = err_q;
  // Host handshake; out-of-range writes complete the handshake but only bump the saturating error count
  always_comb begin
    accept   = host_valid & rdy_q & ~reset;
    push     = accept & (host_addr < AW'(CELLS));
    pop      = (state_q == DRAIN) & ~scan_req & ~reset;
    cnt_d    = cnt_q + LW'(push) - LW'(pop);
    wptr_d   = wptr_q + PW'(push);
    rptr_d   = rptr_q + PW'(pop);
    rdy_d    = cnt_d != LW'(FIFO_DEPTH);
    err_d    = (accept & ~push & (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
    rvalid_d = scan_req;
  end
  // Port arbitration: scan read, then fill, then FIFO head; an idle port keeps its last address
  always_comb begin
    ram_we    = fill_we | pop;
    ram_addr  = scan_req ? scan_addr : fill_we ? fill_addr : pop ? fifo_addr_q[rptr_q] : addr_q;
    ram_wdata = fill_we ? fill_data : pop ? fifo_data_q[rptr_q] : '0;
    addr_d    = ram_addr;
  end
`ifdef CHAR_CLEAR_EN
  assign clear_busy = state_q == CLEAR;
  // Fill sequencing: latch the fill word, walk every cell on free cycles, then resume draining
  always_comb begin
    fill_we   = (state_q == CLEAR) & ~scan_req & ~reset;
    fill_addr = fill_q;
    fill_data = clr_q;
    clr_go    = clear_start & (state_q != CLEAR);
    fill_d    = (state_q == CLEAR) ? fill_q + AW'(fill_we) : '0;
    clr_d     = clr_go ? clear_data : clr_q;
    state_d   = (state_q == CLEAR) ?
                  ((fill_we & (fill_q == AW'(CELLS - 1))) ? ((cnt_d != '0) ? DRAIN : IDLE) : CLEAR) :
                clr_go ? CLEAR : ((cnt_d != '0) ? DRAIN : IDLE);
  end
`else
  assign clear_busy = 1'b0;
  // Without the fill, the FSM only tracks whether the FIFO holds work
  always_comb begin
    fill_we   = 1'b0;
    fill_addr = '0;
    fill_data = '0;
    state_d   = (cnt_d != '0) ? DRAIN : IDLE;
  end
`endif
  // Registered FSM, FIFO pointers and status outputs; reset drops any pending writes
  always_ff @(posedge clk50) begin
    if (reset) begin
      state_q  <= IDLE;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      rdy_q    <= 1'b0;
      rvalid_q <= 1'b0;
      addr_q   <= '0;
      err_q    <= '0;
`ifdef CHAR_CLEAR_EN
      fill_q   <= '0;
      clr_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      rdy_q    <= rdy_d;
      rvalid_q <= rvalid_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
`ifdef CHAR_CLEAR_EN
      fill_q   <= fill_d;
      clr_q    <= clr_d;
`endif
    end
  end
  // FIFO storage; the pointers alone define which entries are live, so it needs no reset
  always_ff @(posedge clk50) begin
    if (push) begin
      fifo_addr_q[wptr_q] <= host_addr;
      fifo_data_q[wptr_q] <= host_data;
    end
  end
endmodule

// File: tb/tb_char_cell_arbiter.sv
// tb_char_cell_arbiter: scoreboard bench for char_cell_arbiter (covers CHAR_CLEAR_EN when defined)
module tb_char_cell_arbiter;
  logic        clk50 = 1'b0;
  logic        reset;
  logic        host_valid, host_ready;
  logic [10:0] host_addr;
  logic [9:0]  host_data;
  logic        scan_req, scan_rvalid;
  logic [10:0] scan_addr;
  logic [9:0]  scan_rdata;
  logic [10:0] ram_addr;
  logic        ram_we;
  logic [9:0]  ram_wdata, ram_rdata;
  logic        clear_start, clear_busy;
  logic [9:0]  clear_data;
  logic [2:0]  fifo_level;
  logic [7:0]  err_cnt;
  int checks = 0;
  int failures = 0;
  int busy_n;
  typedef struct packed {logic [10:0] a; logic [9:0] d;} wr_t;
  wr_t wq[$];
  logic [9:0] sq[$];
  logic [9:0] ram [0:2047];
  bit wr [0:2047];

  char_cell_arbiter dut (
    .clk50(clk50), .reset(reset),
    .host_valid(host_valid), .host_ready(host_ready), .host_addr(host_addr), .host_data(host_data),
    .scan_req(scan_req), .scan_addr(scan_addr), .scan_rvalid(scan_rvalid), .scan_rdata(scan_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .clear_start(clear_start), .clear_data(clear_data), .clear_busy(clear_busy),
    .fifo_level(fifo_level), .err_cnt(err_cnt)
  );

  always #10 clk50 = ~clk50;

  function automatic logic [9:0] f(int a);
    return 10'(a * 37 + 11);
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk50);
    #1;
  endtask

  always @(posedge clk50) begin
    if (ram_we) begin
      ram[ram_addr] <= ram_wdata;
      wr[ram_addr] <= 1'b1;
    end
    ram_rdata <= wr[ram_addr] ? ram[ram_addr] : f(int'(ram_addr));
  end

  always @(negedge clk50) begin
    wr_t e;
    logic [9:0] r;
    if (scan_req) chk("no_we_on_scan", 32'(ram_we), 0);
    if (ram_we) begin
      if (wq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write addr=%0d data=%0h expected=none", ram_addr, ram_wdata);
      end else begin
        e = wq.pop_front();
        chk("wr_addr", 32'(ram_addr), 32'(e.a));
        chk("wr_data", 32'(ram_wdata), 32'(e.d));
      end
    end
    if (scan_rvalid) begin
      if (sq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rvalid data=%0h expected=none", scan_rdata);
      end else begin
        r = sq.pop_front();
        chk("scan_rdata", 32'(scan_rdata), 32'(r));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; host_valid = 1'b0; host_addr = '0; host_data = '0;
    scan_req = 1'b0; scan_addr = '0; clear_start = 1'b0; clear_data = '0;
    step(); step();
    reset = 1'b0;
    @(negedge clk50);
    chk("rst_ready", 32'(host_ready), 0);
    chk("rst_rvalid", 32'(scan_rvalid), 0);
    chk("rst_we", 32'(ram_we), 0);
    chk("rst_addr", 32'(ram_addr), 0);
    chk("rst_wdata", 32'(ram_wdata), 0);
    chk("rst_busy", 32'(clear_busy), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_err", 32'(err_cnt), 0);
    step();
    @(negedge clk50);
    chk("rst_ready_after", 32'(host_ready), 1);
    // single write lands the cycle after acceptance, for exactly one cycle
    step();
    host_valid = 1'b1; host_addr = 11'd5; host_data = 10'h3A5;
    wq.push_back({11'd5, 10'h3A5});
    @(negedge clk50);
    chk("t1_ready", 32'(host_ready), 1);
    chk("t1_no_we_accept_cycle", 32'(ram_we), 0);
    step();
    host_valid = 1'b0;
    @(negedge clk50);
    chk("t1_we", 32'(ram_we), 1);
    chk("t1_addr", 32'(ram_addr), 5);
    chk("t1_wdata", 32'(ram_wdata), 32'h3A5);
    step();
    @(negedge clk50);
    chk("t1_we_once", 32'(ram_we), 0);
    // FIFO fills under scan priority; pending writes do not affect scan data
    for (int i = 0; i < 10; i++) begin
      step();
      scan_req = 1'b1; scan_addr = 11'(200 + i);
      sq.push_back(f(200 + i));
      host_valid = (i < 5); host_addr = 11'(200 + i); host_data = 10'(10'h3C0 + i);
      if (i < 4) wq.push_back({11'(200 + i), 10'(10'h3C0 + i)});
      @(negedge clk50);
      if (i < 4) chk("t2_ready", 32'(host_ready), 1);
      if (i == 4) begin
        chk("t2_full_ready", 32'(host_ready), 0);
        chk("t2_full_level", 32'(fifo_level), 4);
      end
      chk("t2_no_we", 32'(ram_we), 0);
    end
    for (int j = 0; j < 4; j++) begin
      step();
      scan_req = 1'b0; host_valid = 1'b0;
      @(negedge clk50);
      chk("t2_drain_we", 32'(ram_we), 1);
      chk("t2_drain_addr", 32'(ram_addr), 32'(200 + j));
      if (j == 1) chk("t2_ready_again", 32'(host_ready), 1);
    end
    step();
    @(negedge clk50);
    chk("t2_empty_level", 32'(fifo_level), 0);
    chk("t2_empty_we", 32'(ram_we), 0);
    // scan read timing and idle address hold
    step();
    scan_req = 1'b1; scan_addr = 11'd41;
    sq.push_back(f(41));
    @(negedge clk50);
    chk("t3_addr", 32'(ram_addr), 41);
    chk("t3_we", 32'(ram_we), 0);
    step();
    scan_req = 1'b0;
    @(negedge clk50);
    chk("t3_rvalid", 32'(scan_rvalid), 1);
    chk("t3_rdata", 32'(scan_rdata), 32'(f(41)));
    chk("t3_idle_addr_hold", 32'(ram_addr), 41);
    step();
    @(negedge clk50);
    chk("t3_rvalid_pulse", 32'(scan_rvalid), 0);
    // out-of-range writes
    step();
    host_valid = 1'b1; host_addr = 11'd1200; host_data = 10'h111;
    @(negedge clk50);
    chk("t4_ready", 32'(host_ready), 1);
    step();
    host_valid = 1'b0;
    @(negedge clk50);
    chk("t4_err_one", 32'(err_cnt), 1);
    chk("t4_no_we", 32'(ram_we), 0);
    chk("t4_level", 32'(fifo_level), 0);
    for (int i = 0; i < 300; i++) begin
      step();
      host_valid = 1'b1; host_addr = 11'(1200 + i % 848);
    end
    step();
    host_valid = 1'b0;
    @(negedge clk50);
    chk("t4_err_sat", 32'(err_cnt), 255);
    chk("t4_ready_kept", 32'(host_ready), 1);
    // reset with writes pending
    for (int i = 0; i < 3; i++) begin
      step();
      scan_req = 1'b1; scan_addr = 11'(300 + i);
      sq.push_back(f(300 + i));
      host_valid = 1'b1; host_addr = 11'(500 + i); host_data = 10'(10'h2A0 + i);
      wq.push_back({11'(500 + i), 10'(10'h2A0 + i)});
    end
    step();
    host_valid = 1'b0; scan_addr = 11'd303;
    sq.push_back(f(303));
    @(negedge clk50);
    chk("t6_level_pending", 32'(fifo_level), 3);
    step();
    scan_req = 1'b0; reset = 1'b1;
    wq.delete();
    @(negedge clk50);
    chk("t6_we_in_reset", 32'(ram_we), 0);
    step();
    reset = 1'b0;
    @(negedge clk50);
    chk("t6_level", 32'(fifo_level), 0);
    chk("t6_ready_low", 32'(host_ready), 0);
    chk("t6_err_cleared", 32'(err_cnt), 0);
    chk("t6_we_after", 32'(ram_we), 0);
    step();
    @(negedge clk50);
    chk("t6_ready", 32'(host_ready), 1);
    chk("t6_we_after2", 32'(ram_we), 0);
`ifdef CHAR_CLEAR_EN
    // screen fill with periodic scans and a host write queued behind it
    step();
    clear_start = 1'b1; clear_data = 10'h0;
    for (int a = 0; a < 1200; a++) wq.push_back({11'(a), 10'h0});
    busy_n = 0;
    for (int c = 1; c < 3000; c++) begin
      step();
      clear_start = (c == 10); clear_data = (c == 10) ? 10'h3FF : 10'h0;
      scan_req = (c % 32 == 0); scan_addr = 11'd1199;
      if (c % 32 == 0) sq.push_back(f(1199));
      host_valid = (c == 5); host_addr = 11'd0; host_data = 10'h155;
      if (c == 5) wq.push_back({11'd0, 10'h155});
      @(negedge clk50);
      if (c == 5) chk("t5_ready_in_clear", 32'(host_ready), 1);
      if (c == 100) chk("t5_fifo_stalled", 32'(fifo_level), 1);
      if (!clear_busy) break;
      busy_n++;
    end
    chk("t5_busy_cycles", 32'(busy_n), 1238);
    chk("t5_host_we", 32'(ram_we), 1);
    chk("t5_host_addr", 32'(ram_addr), 0);
    chk("t5_host_wdata", 32'(ram_wdata), 32'h155);
    step();
    scan_req = 1'b0; host_valid = 1'b0;
    @(negedge clk50);
    chk("t5_level_end", 32'(fifo_level), 0);
    chk("t5_we_end", 32'(ram_we), 0);
`else
    // without the fill option a clear request does nothing
    step();
    clear_start = 1'b1; clear_data = 10'h2AA;
    @(negedge clk50);
    chk("t5_busy_tied", 32'(clear_busy), 0);
    step();
    clear_start = 1'b0;
    @(negedge clk50);
    chk("t5_busy_tied2", 32'(clear_busy), 0);
    chk("t5_no_we", 32'(ram_we), 0);
`endif
    step();
    step();
    @(negedge clk50);
    chk("sb_writes_drained", 32'(wq.size()), 0);
    chk("sb_reads_drained", 32'(sq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
